idma_irq_coalesce: RTL and testbench

- Parametrised interrupt pending/enable/coalescing unit for iDMA backends; generalises the two-bit read/write pending register (rip/wip) to NumChannels channels.
- Each channel has two event sources: read-done (source 2c) and write-done (source 2c+1).
- Events are counted and raised as pending only when a programmable count threshold is reached or an idle timeout expires.
- Sits between the iDMA backend done strobes and the platform interrupt controller; software programs it over a 64-bit register bus.

---
 rtl/idma_irq_pkg.sv | 34 +++
 rtl/idma_irq_coalesce_src.sv | 50 +++++
 rtl/idma_irq_coalesce.sv | 134 +++++++++++++
 tb/tb_idma_irq_coalesce.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_irq_pkg.sv
// Shared constants and helpers for the iDMA interrupt pending/enable/coalescing unit.
package idma_irq_pkg;

  localparam logic [31:0] OFF_IPSR     = 32'h00;
  localparam logic [31:0] OFF_IER      = 32'h08;
  localparam logic [31:0] OFF_THR      = 32'h10;
  localparam logic [31:0] OFF_TMO      = 32'h18;
  localparam logic [31:0] OFF_ISR      = 32'h20;
  localparam logic [31:0] OFF_IPSR_SET = 32'h28;

  typedef enum logic [2:0] {
    SEL_IPSR,
    SEL_IER,
    SEL_THR,
    SEL_TMO,
    SEL_ISR,
    SEL_IPSR_SET,
    SEL_NONE
  } reg_sel_e;

  // Two event sources (read-done, write-done) per channel.
  function automatic int unsigned num_src(int unsigned n_channels);
    return 2 * n_channels;
  endfunction

  function automatic logic [63:0] strb_mask(logic [7:0] strb);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/idma_irq_coalesce_src.sv
// Per-source coalescing engine: counts events and requests a pending set on
// reaching the threshold or when the idle timeout since the first event expires.
module idma_irq_coalesce_src
  import idma_irq_pkg::*;
#(
  parameter int unsigned CntWidth = 8,
  parameter int unsigned TmoWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ev_i,
  input  logic [CntWidth-1:0] thr_i,
  input  logic [TmoWidth-1:0] tmo_i,
  output logic                set_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_n, thr_e;
  logic [TmoWidth-1:0] tmr_q, tmr_d;
  logic                tmo_hit;

  always_comb begin
    thr_e = thr_i;
    if (thr_e == '0) thr_e = CntWidth'(1);
    cnt_n = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(ev_i);
    // Timer starts the cycle after the first event, so a lone event fires TMO+1 cycles later.
    tmo_hit = (tmo_i != '0) && (cnt_q != '0) && (tmr_q == tmo_i - TmoWidth'(1));

    set_o = 1'b0;
    cnt_d = cnt_n;
    tmr_d = '0;
    if ((cnt_n >= thr_e) || tmo_hit) begin
      set_o = 1'b1;
      cnt_d = '0;
      tmr_d = '0;
    end else if ((tmo_i != '0) && (cnt_q != '0)) begin
      tmr_d = tmr_q + TmoWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/idma_irq_coalesce.sv
// Interrupt pending/enable/coalescing unit for iDMA backends: register bus decode,
// IPSR/IER/THR/TMO storage and one coalescing engine per event source.
module idma_irq_coalesce
  import idma_irq_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned CntWidth    = 8,
  parameter int unsigned TmoWidth    = 16,
  parameter int unsigned AddrWidth   = 6,
  localparam int unsigned NumSrc     = num_src(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] r_done_i,
  input  logic [NumChannels-1:0] w_done_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [63:0]            reg_wdata_i,
  input  logic [7:0]             reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [63:0]            reg_rdata_o,
  output logic                   reg_error_o,
  output logic [NumSrc-1:0]      irq_o
);

  logic [NumSrc-1:0]   ev, hw_set;
  logic [NumSrc-1:0]   ipsr_q, ipsr_d, ier_q, ier_d;
  logic [CntWidth-1:0] thr_q, thr_d;
  logic [TmoWidth-1:0] tmo_q, tmo_d;
  logic [63:0]         wmask, ipsr_x, ier_x, isr_x;
  logic [31:0]         addr_w;
  logic                wr_en;
  reg_sel_e            sel;
  logic                unused_wdata;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ev
    assign ev[2*c]   = r_done_i[c];
    assign ev[2*c+1] = w_done_i[c];
  end

  for (genvar s = 0; s < NumSrc; s++) begin : g_src
    idma_irq_coalesce_src #(
      .CntWidth(CntWidth),
      .TmoWidth(TmoWidth)
    ) u_src (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .ev_i (ev[s]),
      .thr_i(thr_q),
      .tmo_i(tmo_q),
      .set_o(hw_set[s])
    );
  end

  // Bus handshake: every request is accepted in the cycle it is presented
  // (ready = valid); read data/error are combinational, writes land on the next edge.
  assign reg_ready_o  = reg_valid_i;
  assign wr_en        = reg_valid_i && reg_write_i && (sel != SEL_NONE);
  assign wmask        = strb_mask(reg_wstrb_i);
  assign reg_error_o  = reg_valid_i && (sel == SEL_NONE);
  assign irq_o        = ipsr_q & ier_q;
  assign unused_wdata = ^{reg_wdata_i, wmask};

  always_comb begin
    addr_w = 32'(reg_addr_i);
    case (addr_w)
      OFF_IPSR:     sel = SEL_IPSR;
      OFF_IER:      sel = SEL_IER;
      OFF_THR:      sel = SEL_THR;
      OFF_TMO:      sel = SEL_TMO;
      OFF_ISR:      sel = SEL_ISR;
      OFF_IPSR_SET: sel = SEL_IPSR_SET;
      default:      sel = SEL_NONE;
    endcase
  end

  always_comb begin
    ipsr_d = ipsr_q;
    ier_d  = ier_q;
    thr_d  = thr_q;
    tmo_d  = tmo_q;
    for (int i = 0; i < NumSrc; i++) begin
      if (wr_en && wmask[i]) begin
        if ((sel == SEL_IPSR) && reg_wdata_i[i])     ipsr_d[i] = 1'b0;
        if ((sel == SEL_IPSR_SET) && reg_wdata_i[i]) ipsr_d[i] = 1'b1;
        if (sel == SEL_IER)                          ier_d[i]  = reg_wdata_i[i];
      end
    end
    for (int i = 0; i < CntWidth; i++) begin
      if (wr_en && (sel == SEL_THR) && wmask[i]) thr_d[i] = reg_wdata_i[i];
    end
    for (int i = 0; i < TmoWidth; i++) begin
      if (wr_en && (sel == SEL_TMO) && wmask[i]) tmo_d[i] = reg_wdata_i[i];
    end
    // Hardware set is applied last so it wins over a simultaneous W1C.
    ipsr_d = ipsr_d | hw_set;
  end

  always_comb begin
    ipsr_x = '0;
    ier_x  = '0;
    isr_x  = '0;
    ipsr_x[NumSrc-1:0] = ipsr_q;
    ier_x[NumSrc-1:0]  = ier_q;
    isr_x[NumSrc-1:0]  = ipsr_q & ier_q;
    reg_rdata_o = '0;
    if (reg_valid_i && !reg_write_i) begin
      case (sel)
        SEL_IPSR: reg_rdata_o = ipsr_x;
        SEL_IER:  reg_rdata_o = ier_x;
        SEL_THR:  reg_rdata_o[CntWidth-1:0] = thr_q;
        SEL_TMO:  reg_rdata_o[TmoWidth-1:0] = tmo_q;
        SEL_ISR:  reg_rdata_o = isr_x;
        default:  reg_rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ipsr_q <= '0;
      ier_q  <= '0;
      thr_q  <= CntWidth'(1);
      tmo_q  <= '0;
    end else begin
      ipsr_q <= ipsr_d;
      ier_q  <= ier_d;
      thr_q  <= thr_d;
      tmo_q  <= tmo_d;
    end
  end

endmodule

// File: tb/tb_idma_irq_coalesce.sv
// Directed bench for idma_irq_coalesce: register vector table plus hand-written
// sequences for coalescing, timeout, races, masking and asynchronous reset.
module tb_idma_irq_coalesce;

  localparam int unsigned NCH = 2;
  localparam int unsigned NS  = 2 * NCH;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] r_done = '0;
  logic [NCH-1:0] w_done = '0;
  logic           reg_valid = 1'b0;
  logic           reg_write = 1'b0;
  logic [5:0]     reg_addr = '0;
  logic [63:0]    reg_wdata = '0;
  logic [7:0]     reg_wstrb = '0;
  logic           reg_ready;
  logic [63:0]    reg_rdata;
  logic           reg_error;
  logic [NS-1:0]  irq;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vecs[$];

  idma_irq_coalesce #(
    .NumChannels(NCH),
    .CntWidth(8),
    .TmoWidth(16),
    .AddrWidth(6)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .r_done_i   (r_done),
    .w_done_i   (w_done),
    .reg_valid_i(reg_valid),
    .reg_write_i(reg_write),
    .reg_addr_i (reg_addr),
    .reg_wdata_i(reg_wdata),
    .reg_wstrb_i(reg_wstrb),
    .reg_ready_o(reg_ready),
    .reg_rdata_o(reg_rdata),
    .reg_error_o(reg_error),
    .irq_o      (irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_done = '0;
    w_done = '0;
    reg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Driver tasks
  task automatic reg_wr(logic [5:0] addr, logic [63:0] data, logic [7:0] strb = 8'hFF);
    reg_valid = 1'b1;
    reg_write = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    reg_wstrb = strb;
    step();
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic reg_rd_chk(string name, logic [5:0] addr, logic [63:0] exp);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = addr;
    #1;
    chk(name, reg_rdata, exp);
    step();
    reg_valid = 1'b0;
  endtask

  task automatic add(logic wr, logic [5:0] addr, logic [63:0] wdata, logic [7:0] wstrb,
                     logic [63:0] exp_rdata, logic exp_err, string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    add(0, 6'h00, 0, 0, 64'h0, 0, "rst_ipsr");
    add(0, 6'h08, 0, 0, 64'h0, 0, "rst_ier");
    add(0, 6'h10, 0, 0, 64'h1, 0, "rst_thr");
    add(0, 6'h18, 0, 0, 64'h0, 0, "rst_tmo");
    add(0, 6'h20, 0, 0, 64'h0, 0, "rst_isr");
    add(0, 6'h30, 0, 0, 64'h0, 1, "unmapped_30");
    add(0, 6'h04, 0, 0, 64'h0, 1, "misaligned_04");
    add(1, 6'h08, 64'hF, 8'h00, 0, 0, "ier_wr_nostrb");
    add(0, 6'h08, 0, 0, 64'h0, 0, "ier_nostrb_rd");
    add(1, 6'h08, 64'hFF, 8'hFF, 0, 0, "ier_wr");
    add(0, 6'h08, 0, 0, 64'hF, 0, "ier_rd");
    add(1, 6'h10, 64'h1AB, 8'h01, 0, 0, "thr_wr");
    add(0, 6'h10, 0, 0, 64'hAB, 0, "thr_rd");
    add(1, 6'h18, 64'h1234, 8'h02, 0, 0, "tmo_wr_byte1");
    add(0, 6'h18, 0, 0, 64'h1200, 0, "tmo_rd");
    add(1, 6'h20, 64'hFFFF, 8'hFF, 0, 0, "isr_wr_ignored");
    add(0, 6'h20, 0, 0, 64'h0, 0, "isr_rd_after_wr");
    add(1, 6'h28, 64'h5, 8'hFF, 0, 0, "ipsr_set_wr");
    add(0, 6'h28, 0, 0, 64'h0, 0, "ipsr_set_rd0");
    add(0, 6'h00, 0, 0, 64'h5, 0, "ipsr_sw_set");
    add(0, 6'h20, 0, 0, 64'h5, 0, "isr_sw_set");
    add(1, 6'h30, 64'h0, 8'hFF, 0, 1, "unmapped_wr");
    add(0, 6'h08, 0, 0, 64'hF, 0, "ier_after_unmapped");
    add(1, 6'h00, 64'h1, 8'hFF, 0, 0, "ipsr_w1c");
    add(0, 6'h00, 0, 0, 64'h4, 0, "ipsr_after_w1c");

    #2;
    chk("rst_irq_async", irq, 0);
    do_reset();
    chk("rst_irq", irq, 0);
    chk("ready_idle", reg_ready, 0);

    // Register vector table
    foreach (vecs[i]) begin
      reg_valid = 1'b1;
      reg_write = vecs[i].wr;
      reg_addr  = vecs[i].addr;
      reg_wdata = vecs[i].wdata;
      reg_wstrb = vecs[i].wstrb;
      #1;
      chk({vecs[i].name, "_err"}, reg_error, vecs[i].exp_err);
      chk({vecs[i].name, "_ready"}, reg_ready, 1);
      if (!vecs[i].wr) chk(vecs[i].name, reg_rdata, vecs[i].exp_rdata);
      step();
      reg_valid = 1'b0;
      reg_write = 1'b0;
    end
    chk("table_irq", irq, 4'h4);

    // Immediate mode
    do_reset();
    reg_wr(6'h08, 64'hF);
    r_done = 2'b10;
    chk("imm_irq_before", irq, 0);
    step();
    r_done = '0;
    chk("imm_irq", irq, 4'b0100);
    reg_wr(6'h00, 64'h4);
    chk("imm_w1c_irq", irq, 0);

    // Coalescing
    do_reset();
    reg_wr(6'h08, 64'hF);
    reg_wr(6'h10, 64'h3);
    for (int p = 0; p < 3; p++) begin
      w_done = 2'b01;
      step();
      w_done = '0;
      chk($sformatf("coal_pulse%0d", p), irq, (p == 2) ? 4'b0010 : 4'b0000);
      if (p < 2) begin
        for (int k = 0; k < 4; k++) step();
        chk($sformatf("coal_gap%0d", p), irq, 0);
      end
    end
    reg_wr(6'h00, 64'h2);
    chk("coal_w1c", irq, 0);
    w_done = 2'b01;
    step();
    w_done = '0;
    chk("coal_4th_pulse", irq, 0);

    // Timeout
    do_reset();
    reg_wr(6'h08, 64'hF);
    reg_wr(6'h10, 64'h8);
    reg_wr(6'h18, 64'd10);
    r_done = 2'b01;
    step();
    r_done = '0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("tmo_wait_t%0d", k), irq, 0);
      step();
    end
    chk("tmo_fire_t11", irq, 4'b0001);

    do_reset();
    reg_wr(6'h08, 64'hF);
    reg_wr(6'h10, 64'h8);
    r_done = 2'b01;
    step();
    r_done = '0;
    for (int k = 0; k < 40; k++) step();
    chk("tmo0_irq", irq, 0);
    reg_rd_chk("tmo0_ipsr", 6'h00, 0);

    // Races: hardware set beats W1C
    do_reset();
    reg_wr(6'h08, 64'hF);
    r_done = 2'b01;
    step();
    chk("race_pre", irq, 4'b0001);
    reg_wr(6'h00, 64'h1);
    r_done = '0;
    chk("race_set_wins", irq, 4'b0001);
    reg_wr(6'h00, 64'h1);
    chk("race_clear_after", irq, 0);

    // Event every cycle with THR = 1
    r_done = 2'b10;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("every_cycle%0d", k), irq, 4'b0100);
    end
    reg_wr(6'h00, 64'h4);
    chk("every_w1c_held", irq, 4'b0100);
    r_done = '0;
    reg_wr(6'h00, 64'h4);
    reg_wr(6'h10, 64'h2);
    r_done = 2'b10;
    step();
    r_done = '0;
    chk("every_cnt_zero", irq, 0);
    r_done = 2'b10;
    step();
    r_done = '0;
    chk("every_thr2_fire", irq, 4'b0100);

    // Masking
    do_reset();
    w_done = 2'b10;
    step();
    w_done = '0;
    chk("mask_irq", irq, 0);
    reg_rd_chk("mask_isr", 6'h20, 0);
    reg_rd_chk("mask_ipsr", 6'h00, 64'h8);
    reg_valid = 1'b1;
    reg_write = 1'b1;
    reg_addr  = 6'h08;
    reg_wdata = 64'h8;
    reg_wstrb = 8'hFF;
    #1;
    chk("mask_ier_same_cycle", irq, 0);
    step();
    reg_valid = 1'b0;
    reg_write = 1'b0;
    chk("mask_ier_next", irq, 4'b1000);

    // Asynchronous reset mid-count
    do_reset();
    reg_wr(6'h08, 64'hF);
    reg_wr(6'h10, 64'h8);
    reg_wr(6'h18, 64'h20);
    reg_wr(6'h28, 64'h3);
    r_done = 2'b01;
    for (int k = 0; k < 7; k++) step();
    r_done = '0;
    chk("arst_pre_irq", irq, 4'b0011);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_irq", irq, 0);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = 6'h10;
    #1;
    chk("arst_thr", reg_rdata, 1);
    reg_addr = 6'h08;
    #1;
    chk("arst_ier", reg_rdata, 0);
    reg_valid = 1'b0;
    step();
    rst = 1'b0;
    reg_wr(6'h08, 64'hF);
    reg_wr(6'h10, 64'h8);
    r_done = 2'b01;
    step();
    r_done = '0;
    chk("arst_cnt_cleared", irq, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
